// File: rtl/vga_sync_generator.sv
// VGA timing: x/y raster counters with hsync/vsync/video_on decoded in the same cycle as x/y, plus line/frame pulses.
// Latency: all outputs are registered and aligned with x/y. pix_en=0 freezes every output; the pulses drop to 0.
module vga_sync_generator #(
  parameter int   H_VISIBLE = 640,
  parameter int   H_FRONT   = 16,
  parameter int   H_SYNC    = 96,
  parameter int   H_BACK    = 48,
  parameter int   V_VISIBLE = 480,
  parameter int   V_FRONT   = 10,
  parameter int   V_SYNC    = 2,
  parameter int   V_BACK    = 33,
  parameter logic SYNC_POL  = 1'b0
) (
  input  logic       clock_in,
  input  logic       reset,
  input  logic       pix_en,
  output logic       hsync,
  output logic       vsync,
  output logic       video_on,
  output logic [9:0] x,
  output logic [9:0] y,
  output logic       line_start,
  output logic       frame_start
);

  localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

  localparam logic [9:0] X_LAST   = 10'(H_TOTAL - 1);
  localparam logic [9:0] Y_LAST   = 10'(V_TOTAL - 1);
  localparam logic [9:0] X_VIS    = 10'(H_VISIBLE);
  localparam logic [9:0] Y_VIS    = 10'(V_VISIBLE);
  localparam logic [9:0] HS_BEGIN = 10'(H_VISIBLE + H_FRONT);
  localparam logic [9:0] HS_END   = 10'(H_VISIBLE + H_FRONT + H_SYNC);
  localparam logic [9:0] VS_BEGIN = 10'(V_VISIBLE + V_FRONT);
  localparam logic [9:0] VS_END   = 10'(V_VISIBLE + V_FRONT + V_SYNC);

  logic       x_wrap;
  logic       y_wrap;
  logic [9:0] x_nxt;
  logic [9:0] y_nxt;
  logic       hs_act_nxt;
  logic       vs_act_nxt;
  logic       video_nxt;

  // Wrap on >= so a counter can never escape its legal range.
  always_comb begin
    x_wrap = (x >= X_LAST);
    y_wrap = (y >= Y_LAST);
    x_nxt  = x_wrap ? 10'd0 : x + 10'd1;
    y_nxt  = y;
    if (x_wrap) begin
      y_nxt = y_wrap ? 10'd0 : y + 10'd1;
    end
    hs_act_nxt = (x_nxt >= HS_BEGIN) && (x_nxt < HS_END);
    vs_act_nxt = (y_nxt >= VS_BEGIN) && (y_nxt < VS_END);
    video_nxt  = (x_nxt < X_VIS) && (y_nxt < Y_VIS);
  end

  // Decoding from the next-state counters keeps sync/video aligned with x/y.
  always_ff @(posedge clock_in) begin
    if (reset) begin
      x           <= 10'd0;
      y           <= 10'd0;
      hsync       <= ~SYNC_POL;
      vsync       <= ~SYNC_POL;
      video_on    <= 1'b0;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      line_start  <= pix_en & x_wrap;
      frame_start <= pix_en & x_wrap & y_wrap;
      if (pix_en) begin
        x        <= x_nxt;
        y        <= y_nxt;
        hsync    <= hs_act_nxt ? SYNC_POL : ~SYNC_POL;
        vsync    <= vs_act_nxt ? SYNC_POL : ~SYNC_POL;
        video_on <= video_nxt;
      end
    end
  end

endmodule

// File: tb/tb_vga_sync_generator.sv
// Scoreboard bench: a full-size instance for the 640x480 boundaries and a shrunken instance for whole-frame timing.
module tb_vga_sync_generator;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  logic       rst_a, en_a, hs_a, vs_a, von_a, ls_a, fs_a;
  logic [9:0] x_a, y_a;
  logic       rst_b, en_b, hs_b, vs_b, von_b, ls_b, fs_b;
  logic [9:0] x_b, y_b;

  vga_sync_generator dut_a (
    .clock_in(clk), .reset(rst_a), .pix_en(en_a),
    .hsync(hs_a), .vsync(vs_a), .video_on(von_a),
    .x(x_a), .y(y_a), .line_start(ls_a), .frame_start(fs_a)
  );

  // Small raster: 16 x 12 total, hsync on x 10..12, vsync on y 7..8, visible 8 x 6.
  vga_sync_generator #(
    .H_VISIBLE(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(3),
    .V_VISIBLE(6), .V_FRONT(1), .V_SYNC(2), .V_BACK(3),
    .SYNC_POL(1'b0)
  ) dut_b (
    .clock_in(clk), .reset(rst_b), .pix_en(en_b),
    .hsync(hs_b), .vsync(vs_b), .video_on(von_b),
    .x(x_b), .y(y_b), .line_start(ls_b), .frame_start(fs_b)
  );

  typedef struct {
    int         cyc;
    bit         inst;
    string      nm;
    logic [9:0] x, y;
    logic       hs, vs, von, ls, fs;
  } exp_t;

  exp_t sb[$];
  int   n_vec = 0;
  int   n_err = 0;

  task automatic cmp(input string nm, input string fld, input logic [9:0] act, input logic [9:0] ex);
    n_vec++;
    if (act !== ex) begin
      n_err++;
      $display("FAIL %s.%s got %0d required %0d (cycle %0d)", nm, fld, act, ex, cyc);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic push(input bit inst, input string nm, input logic [9:0] ex, input logic [9:0] ey,
                      input logic hs, input logic vs, input logic von, input logic ls, input logic fs);
    exp_t t;
    t.cyc = cyc; t.inst = inst; t.nm = nm;
    t.x = ex; t.y = ey; t.hs = hs; t.vs = vs; t.von = von; t.ls = ls; t.fs = fs;
    sb.push_back(t);
  endtask

  // Monitor: every expectation is tagged with the cycle it describes and is checked mid-cycle.
  exp_t e;
  always @(negedge clk) begin
    while (sb.size() > 0 && sb[0].cyc <= cyc) begin
      e = sb.pop_front();
      if (e.cyc != cyc) begin
        n_vec++;
        n_err++;
        $display("FAIL %s stale: checked at cycle %0d, required cycle %0d", e.nm, cyc, e.cyc);
      end else if (!e.inst) begin
        cmp(e.nm, "x", x_a, e.x);
        cmp(e.nm, "y", y_a, e.y);
        cmp(e.nm, "hsync", {9'd0, hs_a}, {9'd0, e.hs});
        cmp(e.nm, "vsync", {9'd0, vs_a}, {9'd0, e.vs});
        cmp(e.nm, "video_on", {9'd0, von_a}, {9'd0, e.von});
        cmp(e.nm, "line_start", {9'd0, ls_a}, {9'd0, e.ls});
        cmp(e.nm, "frame_start", {9'd0, fs_a}, {9'd0, e.fs});
      end else begin
        cmp(e.nm, "x", x_b, e.x);
        cmp(e.nm, "y", y_b, e.y);
        cmp(e.nm, "hsync", {9'd0, hs_b}, {9'd0, e.hs});
        cmp(e.nm, "vsync", {9'd0, vs_b}, {9'd0, e.vs});
        cmp(e.nm, "video_on", {9'd0, von_b}, {9'd0, e.von});
        cmp(e.nm, "line_start", {9'd0, ls_b}, {9'd0, e.ls});
        cmp(e.nm, "frame_start", {9'd0, fs_b}, {9'd0, e.fs});
      end
    end
  end

  initial begin
    int fs_cnt;
    int fs_at;
    int fs_gap;
    int vlow;

    rst_a = 1'b1; en_a = 1'b1;
    rst_b = 1'b1; en_b = 1'b0;
    tick; tick;
    push(0, "a_reset", 10'd0, 10'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    push(1, "b_reset", 10'd0, 10'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);

    // Full-size instance: first advance, then the horizontal boundaries of line 0.
    rst_a = 1'b0; en_a = 1'b0; tick;
    push(0, "a_hold00", 10'd0, 10'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    en_a = 1'b1; tick;
    push(0, "a_adv1", 10'd1, 10'd0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    repeat (638) tick;
    push(0, "a_x639", 10'd639, 10'd0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    tick;
    push(0, "a_x640", 10'd640, 10'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    repeat (15) tick;
    push(0, "a_x655", 10'd655, 10'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    tick;
    push(0, "a_x656", 10'd656, 10'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    repeat (95) tick;
    push(0, "a_x751", 10'd751, 10'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    tick;
    push(0, "a_x752", 10'd752, 10'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);

    // Enable gating across the end of line 10: pix_en 1,0,0,1.
    repeat (8046) tick;
    push(0, "a_x798y10", 10'd798, 10'd10, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    tick;
    push(0, "a_gate1", 10'd799, 10'd10, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    en_a = 1'b0; tick;
    push(0, "a_gate2", 10'd799, 10'd10, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    tick;
    push(0, "a_gate3", 10'd799, 10'd10, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    en_a = 1'b1; tick;
    push(0, "a_gate4", 10'd0, 10'd11, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
    tick;
    push(0, "a_gate5", 10'd1, 10'd11, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    en_a = 1'b0;

    // Small instance: mid-frame reset while hsync is active.
    rst_b = 1'b0; en_b = 1'b1;
    repeat (76) tick;
    push(1, "b_pre_rst", 10'd12, 10'd4, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    rst_b = 1'b1; tick;
    push(1, "b_mid_rst", 10'd0, 10'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    rst_b = 1'b0; tick;
    push(1, "b_adv1", 10'd1, 10'd0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);

    // Two full frames: frame_start position, spacing, and vsync-low length.
    fs_cnt = 0; fs_at = -1; fs_gap = 0; vlow = 0;
    for (int i = 1; i <= 384; i++) begin
      tick;
      if (fs_b) begin
        fs_cnt++;
        if (fs_at < 0) fs_at = i;
        else fs_gap = i - fs_at;
      end
      if (i <= 192 && vs_b == 1'b0) vlow++;
      if (i == 190) push(1, "b_last_px", 10'd15, 10'd11, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
      if (i == 191) push(1, "b_wrap", 10'd0, 10'd0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
      if (i == 192) push(1, "b_post_wrap", 10'd1, 10'd0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    end
    cmp("b_frames", "fs_first", 10'(fs_at), 10'd191);
    cmp("b_frames", "fs_gap", 10'(fs_gap), 10'd192);
    cmp("b_frames", "fs_count", 10'(fs_cnt), 10'd2);
    cmp("b_frames", "vsync_low", 10'(vlow), 10'd32);

    // line_start must not stretch while pix_en is low.
    repeat (14) tick;
    push(1, "b_x15", 10'd15, 10'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    tick;
    push(1, "b_line", 10'd0, 10'd1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
    en_b = 1'b0; tick;
    push(1, "b_line_hold", 10'd0, 10'd1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);

    tick; tick;
    cmp("scoreboard", "left", 10'(sb.size()), 10'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
